// File: rtl/pc_src_reg.sv
// Next-PC source select and program counter register for the fetch stage.
// Optional: define PC_REDIRECT_CNT_EN to enable the taken-redirect counter.
module pc_src_reg #(
    parameter int          WIDTH    = 32,
    parameter int          NSRC     = 4,
    parameter int          SEL_W    = 2,
    parameter int          STEP     = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SEL_W-1:0]            sel,
    input  logic [(NSRC-1)*WIDTH-1:0]   src_bus,
    input  logic                        stall,
    output logic [WIDTH-1:0]            pc,
    output logic [WIDTH-1:0]            pc_plus,
    output logic                        redirect_pending,
    output logic                        sel_err,
    output logic                        align_err,
    output logic [15:0]                 redirect_cnt
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_PC);

    logic [31:0]      sel_ext;
    logic             redir;
    logic             illegal;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] tgt;
    logic             misalign;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             pend_q, pend_d;
    logic             sel_err_q, sel_err_d;
    logic             align_q, align_d;

    assign sel_ext = 32'(sel);
    assign redir   = (sel_ext != 32'd0) && (sel_ext < 32'(NSRC));
    assign illegal = (sel_ext >= 32'(NSRC));

    // Pick the external target slice addressed by sel (slice k-1 for sel=k)
    always_comb begin
        raw = '0;
        for (int k = 1; k < NSRC; k++) begin
            if (sel_ext == 32'(k)) raw = src_bus[(k-1)*WIDTH +: WIDTH];
        end
    end

    assign tgt      = {raw[WIDTH-1:2], 2'b00};
    assign misalign = |raw[1:0];
    assign pc_plus  = pc_q + STEP_W;

    // Next-state: stall buffers redirects, otherwise redirect > pending > sequential
    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        sel_err_d  = 1'b0;
        align_d    = 1'b0;
        if (stall) begin
            if (redir) begin
                pend_tgt_d = tgt;
                pend_d     = 1'b1;
                align_d    = misalign;
            end
        end else if (redir) begin
            pc_d    = tgt;
            pend_d  = 1'b0;
            align_d = misalign;
        end else if (pend_q) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
        end else begin
            pc_d      = pc_plus;
            sel_err_d = illegal;
        end
    end

    // PC, pending redirect buffer and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RST_W;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            sel_err_q  <= 1'b0;
            align_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            sel_err_q  <= sel_err_d;
            align_q    <= align_d;
        end
    end

    assign pc               = pc_q;
    assign redirect_pending = pend_q;
    assign sel_err          = sel_err_q;
    assign align_err        = align_q;

`ifdef PC_REDIRECT_CNT_EN
    logic        load_redir;
    logic [15:0] cnt_q;

    assign load_redir = !stall && (redir || pend_q);

    // Saturating count of redirect targets loaded into pc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else if (load_redir && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign redirect_cnt = cnt_q;
`else
    assign redirect_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_src_reg.sv
// Directed testbench for pc_src_reg (NSRC=4 main instance, NSRC=3 for
// illegal-select checks).
module tb_pc_src_reg;

`ifdef PC_REDIRECT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic [95:0] src_bus;
    logic        stall;
    logic [31:0] pc, pc_plus;
    logic        pend, sel_err, align_err;
    logic [15:0] cnt;

    logic [1:0]  sel2;
    logic [63:0] src_bus2;
    logic        stall2;
    logic [31:0] pc2, pc_plus2;
    logic        pend2, sel_err2, align_err2;
    logic [15:0] cnt2;

    int passed = 0;
    int total  = 0;

    pc_src_reg #(.WIDTH(32), .NSRC(4), .SEL_W(2), .STEP(4),
                 .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .src_bus(src_bus),
        .stall(stall), .pc(pc), .pc_plus(pc_plus),
        .redirect_pending(pend), .sel_err(sel_err),
        .align_err(align_err), .redirect_cnt(cnt)
    );

    pc_src_reg #(.WIDTH(32), .NSRC(3), .SEL_W(2), .STEP(4),
                 .RESET_PC(32'h0000_3000)) dut2 (
        .clk(clk), .rst_n(rst_n), .sel(sel2), .src_bus(src_bus2),
        .stall(stall2), .pc(pc2), .pc_plus(pc_plus2),
        .redirect_pending(pend2), .sel_err(sel_err2),
        .align_err(align_err2), .redirect_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ec(input int n);
        return CNT_ON ? 32'(n) : 32'd0;
    endfunction

    initial begin
        rst_n = 1'b0; sel = 2'd0; src_bus = '0; stall = 1'b0;
        sel2 = 2'd0; src_bus2 = '0; stall2 = 1'b1;
        step(); step();
        chk("rst_pc", pc, 32'h3000);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_selerr", 32'(sel_err), 0);
        chk("rst_alerr", 32'(align_err), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_pcplus", pc_plus, 32'h3004);
        rst_n = 1'b1;
        step(); chk("seq1", pc, 32'h3004);
        step(); chk("seq2", pc, 32'h3008);
        step(); chk("seq3", pc, 32'h300C);
        chk("seq_selerr", 32'(sel_err), 0);
        chk("seq_alerr", 32'(align_err), 0);

        sel = 2'd1; src_bus[31:0] = 32'h0000_4000;
        step(); chk("redir_pc", pc, 32'h4000);
        chk("redir_cnt", 32'(cnt), ec(1));
        sel = 2'd0;
        step(); chk("after_redir", pc, 32'h4004);
        chk("pcplus", pc_plus, 32'h4008);

        stall = 1'b1; sel = 2'd2; src_bus[63:32] = 32'h5000;
        step(); chk("stall1_pc", pc, 32'h4004);
        chk("stall1_pend", 32'(pend), 1);
        sel = 2'd3; src_bus[95:64] = 32'h6000;
        step(); chk("stall2_pc", pc, 32'h4004);
        sel = 2'd0;
        step(); chk("stall3_pc", pc, 32'h4004);
        chk("stall3_pend", 32'(pend), 1);
        chk("stall_cnt", 32'(cnt), ec(1));
        stall = 1'b0;
        step(); chk("release_pc", pc, 32'h6000);
        chk("release_pend", 32'(pend), 0);
        chk("release_cnt", 32'(cnt), ec(2));
        step(); chk("release_seq", pc, 32'h6004);

        stall = 1'b1; sel = 2'd3; src_bus[95:64] = 32'h6000;
        step(); chk("pre_pend", 32'(pend), 1);
        stall = 1'b0; sel = 2'd1; src_bus[31:0] = 32'h7000;
        step(); chk("override_pc", pc, 32'h7000);
        chk("override_pend", 32'(pend), 0);
        sel = 2'd0;
        step(); chk("override_seq", pc, 32'h7004);
        chk("override_cnt", 32'(cnt), ec(3));

        sel = 2'd1; src_bus[31:0] = 32'h4002;
        step(); chk("align_pc", pc, 32'h4000);
        chk("align_pulse", 32'(align_err), 1);
        sel = 2'd0;
        step(); chk("align_clear", 32'(align_err), 0);
        chk("align_seq", pc, 32'h4004);

        sel = 2'd1; src_bus[31:0] = 32'hFFFF_FFFC;
        step(); chk("wrap_plus", pc_plus, 32'h0);
        sel = 2'd0;
        step(); chk("wrap_pc", pc, 32'h0);
        chk("wrap_cnt", 32'(cnt), ec(5));

        stall = 1'b1; sel = 2'd1; src_bus[31:0] = 32'h8001;
        step(); chk("cap_alerr", 32'(align_err), 1);
        chk("cap_pc", pc, 32'h0);
        sel = 2'd0;
        step(); chk("cap_alerr_clr", 32'(align_err), 0);
        stall = 1'b0;
        step(); chk("cap_load", pc, 32'h8000);
        chk("cap_load_alerr", 32'(align_err), 0);

        stall = 1'b1; sel = 2'd2; src_bus[63:32] = 32'h9000;
        step(); chk("ar_pend_set", 32'(pend), 1);
        #2 rst_n = 1'b0;
        #1 chk("ar_pc", pc, 32'h3000);
        chk("ar_pend", 32'(pend), 0);
        chk("ar_cnt", 32'(cnt), 0);
        #1 rst_n = 1'b1;
        stall = 1'b0; sel = 2'd0;
        step(); chk("ar_after", pc, 32'h3004);

        chk("n3_start", pc2, 32'h3000);
        stall2 = 1'b0; sel2 = 2'd3; src_bus2 = {32'hA000, 32'hB000};
        step(); chk("n3_pc", pc2, 32'h3004);
        chk("n3_selerr", 32'(sel_err2), 1);
        chk("n3_pend", 32'(pend2), 0);
        sel2 = 2'd0;
        step(); chk("n3_selerr_clr", 32'(sel_err2), 0);
        chk("n3_seq", pc2, 32'h3008);
        stall2 = 1'b1; sel2 = 2'd3;
        step(); chk("n3_stall_selerr", 32'(sel_err2), 0);
        chk("n3_stall_pc", pc2, 32'h3008);
        step(); chk("n3_stall_selerr2", 32'(sel_err2), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
